perf_event_counter_bank: RTL
============================

# perf_event_counter_bank

Parametrised bank of per-event performance counters fed by the core's event vector. It generalises the single-bit event counter with several additions:
- multi-bit increments per event per cycle;
- per-event enable mask;
- runtime wrap/saturate mode;
- sticky overflow flags;
- an atomic snapshot port with a valid/ready handshake for the monitoring readout logic.

The block sits between the processor's event taps and the continuous-monitoring export path.

## Interface
- NUM_EVENTS, 8, number of independent counters/event slots
- COUNTER_WIDTH, 8, bits per counter; must be ≥ INC_WIDTH
- INC_WIDTH, 1, bits of increment amount per event slot (1 = plain bitmap)
- CLEAR_ON_SNAPSHOT, 0, if 1 a snapshot capture also zeroes live counters and overflow flags

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  global count enable
- event_mask  in  NUM_EVENTS  per-counter enable; bit i gates slot i
- performance_events  in  NUM_EVENTS*INC_WIDTH  slot i = bits [i*INC_WIDTH +: INC_WIDTH], unsigned increment
- saturate_mode  in  1  0 = wrap modulo 2^COUNTER_WIDTH, 1 = clamp at all-ones
- clear  in  1  one-cycle pulse; zeroes live counters and overflow_map
- snapshot_req  in  1  request atomic capture
- snapshot_ready  in  1  consumer accepts snapshot
- counters  out  NUM_EVENTS*COUNTER_WIDTH  live counter values, slot i at [i*COUNTER_WIDTH +: COUNTER_WIDTH]
- overflow_map  out  NUM_EVENTS  sticky per-counter overflow
- overflow_any  out  1  OR of overflow_map
- snapshot_valid  out  1  snapshot outputs hold valid data
- snapshot_counters  out  NUM_EVENTS*COUNTER_WIDTH  captured counters
- snapshot_overflow_map  out  NUM_EVENTS  captured overflow flags

## Operation
- **Reset:** all outputs and registers are 0; the FSM enters IDLE.
- **Per-slot update.** Update priority is rst > clear > snapshot-clear > increment.
  - Let sum = counter_i + inc_i, computed at COUNTER_WIDTH+1 bits. Increment is active when en & event_mask[i]; otherwise inc_i = 0.
  - sum ≤ max: counter_i <= sum.
  - sum > max, wrap mode: counter_i <= sum[COUNTER_WIDTH-1:0]; overflow_map[i] <= 1.
  - sum > max, saturate mode: counter_i <= all-ones; overflow_map[i] <= 1. This includes nonzero increments to an already-saturated counter.
  - overflow_map bits clear only on rst, clear, or a CLEAR_ON_SNAPSHOT capture.
  - clear asserted in the same cycle as an event: the counter becomes 0 and that cycle's increment is dropped.
  - Changing saturate_mode never alters stored values; it affects only subsequent updates.
- **Snapshot FSM** (states IDLE, HOLD):
  - IDLE & snapshot_req: snapshot_counters/snapshot_overflow_map <= current register values (pre-update, i.e. the values on counters/overflow_map that cycle). snapshot_valid <= 1; next state HOLD.
  - HOLD: snapshot outputs are frozen; snapshot_req is ignored.
  - HOLD & snapshot_ready: snapshot_valid <= 0; next state IDLE. A new request is accepted in the following cycle at the earliest.
- **CLEAR_ON_SNAPSHOT = 1**, in the capture cycle:
  - The live counters and overflow_map restart from 0, and that cycle's increments are applied on top (counter_i <= inc_i). No events are lost across a capture.
  - clear in the same cycle as a capture: the snapshot takes pre-clear values; the live counters become 0 and the increments are dropped.
- rst in any state returns to IDLE, with snapshot_valid = 0 and all counters, flags and snapshot data = 0 from the next cycle.

## Timing
- An event in cycle N is visible on counters in cycle N+1. overflow_map and overflow_any update in the same cycle as the wrapped/saturated counter, because overflow_any is registered from the next-state OR.
- snapshot_req in cycle N gives snapshot_valid = 1 from N+1, with data equal to the counters value of cycle N.
- A valid&ready handshake in cycle M gives snapshot_valid = 0 at M+1. The minimum request-to-request spacing is 2 cycles.
- clear in cycle N gives counters = 0 at N+1.
- Full throughput: every slot can increment by up to 2^INC_WIDTH−1 every cycle, with no stalls.
- All outputs are registered; there are no combinational input-to-output paths.

## Test plan
All scenarios use NUM_EVENTS=3, COUNTER_WIDTH=4, INC_WIDTH=2, en=1, mask=111 unless stated otherwise.
- **Basic count:** reset, then slot0 inc=1 for 5 cycles → counters slot0 = 5, slots 1–2 = 0, overflow_map = 000.
- **Wrap vs saturate:** slot1 brought to 14, then inc=3.
  - wrap: slot1 = 1, overflow_map = 010, overflow_any = 1 in the same cycle.
  - repeat with saturate_mode=1: slot1 = 15, then a further inc=1 keeps it at 15 with overflow still set.
- **Mask/enable:** event_mask=101 with all slots inc=1 for 4 cycles → 4,0,4. Then en=0 for 3 cycles → values unchanged.
- **Snapshot handshake, CLEAR_ON_SNAPSHOT=1:** slot0 = 9; snapshot_req with slot0 inc=2 in the same cycle.
  - Next cycle: snapshot slot0 = 9, live slot0 = 2, snapshot_valid = 1.
  - Hold snapshot_ready=0 for 3 cycles, with snapshot_req pulsed meanwhile → data stable and no recapture.
  - ready=1 → valid = 0 on the next cycle.
- **Clear collisions:** clear with slot2 inc=3 in the same cycle → slot2 = 0 and overflow_map = 000. clear together with snapshot_req → snapshot holds the pre-clear values and the live counters are 0.
- **Reset mid-operation:** rst asserted while in HOLD with nonzero counters → next cycle snapshot_valid = 0 and all counters/flags/snapshot data = 0. A snapshot_req two cycles later is accepted normally.

Source files
------------

// File: rtl/perf_event_counter_bank_if.sv
// Snapshot readout port of the performance event counter bank.
// The bank drives the captured data and valid; the monitoring logic drives request and ready.
interface perf_event_counter_bank_if #(
    parameter int unsigned NUM_EVENTS    = 8,
    parameter int unsigned COUNTER_WIDTH = 8
);
    logic                                snapshot_req;
    logic                                snapshot_ready;
    logic                                snapshot_valid;
    logic [NUM_EVENTS*COUNTER_WIDTH-1:0] snapshot_counters;
    logic [NUM_EVENTS-1:0]               snapshot_overflow_map;

    // Counter bank side: produces the snapshot
    modport master (
        input  snapshot_req,
        input  snapshot_ready,
        output snapshot_valid,
        output snapshot_counters,
        output snapshot_overflow_map
    );

    // Readout side: requests and consumes the snapshot
    modport slave (
        output snapshot_req,
        output snapshot_ready,
        input  snapshot_valid,
        input  snapshot_counters,
        input  snapshot_overflow_map
    );
endinterface

// File: rtl/perf_event_counter_bank.sv
// Bank of per-event performance counters with multi-bit increments, per-slot
// enable mask, runtime wrap/saturate mode, sticky overflow flags and an atomic
// snapshot port guarded by a valid/ready handshake.
module perf_event_counter_bank #(
    parameter int unsigned NUM_EVENTS        = 8,
    parameter int unsigned COUNTER_WIDTH     = 8,
    parameter int unsigned INC_WIDTH         = 1,
    parameter int unsigned CLEAR_ON_SNAPSHOT = 0
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                en,
    input  logic [NUM_EVENTS-1:0]               event_mask,
    input  logic [NUM_EVENTS*INC_WIDTH-1:0]     performance_events,
    input  logic                                saturate_mode,
    input  logic                                clear,
    output logic [NUM_EVENTS*COUNTER_WIDTH-1:0] counters,
    output logic [NUM_EVENTS-1:0]               overflow_map,
    output logic                                overflow_any,
    perf_event_counter_bank_if.master           snap
);

    localparam int unsigned SUM_W = COUNTER_WIDTH + 1;
    localparam logic [COUNTER_WIDTH-1:0] CNT_MAX = {COUNTER_WIDTH{1'b1}};

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                              state_q;
    state_t                              state_d;
    logic                                capture_c;
    logic                                restart_c;
    logic [NUM_EVENTS*INC_WIDTH-1:0]     inc_c;
    logic [NUM_EVENTS*COUNTER_WIDTH-1:0] cnt_d;
    logic [NUM_EVENTS-1:0]               ovf_d;

    // One slot's add: returns {overflowed, new counter value}
    function automatic logic [COUNTER_WIDTH:0] slot_update(
        input logic [COUNTER_WIDTH-1:0] cnt,
        input logic [INC_WIDTH-1:0]     inc,
        input logic                     sat
    );
        logic [SUM_W-1:0] sum;
        sum = {1'b0, cnt} + SUM_W'(inc);
        if (sum[COUNTER_WIDTH]) begin
            slot_update = {1'b1, (sat ? CNT_MAX : sum[COUNTER_WIDTH-1:0])};
        end else begin
            slot_update = {1'b0, sum[COUNTER_WIDTH-1:0]};
        end
    endfunction

    // Snapshot FSM next state: capture in IDLE on request, release in HOLD on ready
    always_comb begin
        state_d   = state_q;
        capture_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (snap.snapshot_req) begin
                    capture_c = 1'b1;
                    state_d   = HOLD;
                end
            end
            HOLD: begin
                if (snap.snapshot_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Snapshot FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Gate each slot's increment by the global enable and its mask bit
    always_comb begin
        inc_c = '0;
        for (int i = 0; i < int'(NUM_EVENTS); i++) begin
            if (en && event_mask[i]) begin
                inc_c[i*INC_WIDTH +: INC_WIDTH] = performance_events[i*INC_WIDTH +: INC_WIDTH];
            end
        end
    end

    // A clearing capture restarts the slots from zero so no events are lost across it
    assign restart_c = (CLEAR_ON_SNAPSHOT != 0) && capture_c;

    // Per-slot next value: clear beats capture-restart beats plain increment
    always_comb begin
        cnt_d = counters;
        ovf_d = overflow_map;
        for (int i = 0; i < int'(NUM_EVENTS); i++) begin
            logic [COUNTER_WIDTH:0] upd;
            upd = slot_update(restart_c ? '0 : counters[i*COUNTER_WIDTH +: COUNTER_WIDTH],
                              inc_c[i*INC_WIDTH +: INC_WIDTH], saturate_mode);
            if (clear) begin
                cnt_d[i*COUNTER_WIDTH +: COUNTER_WIDTH] = '0;
                ovf_d[i]                                = 1'b0;
            end else begin
                cnt_d[i*COUNTER_WIDTH +: COUNTER_WIDTH] = upd[COUNTER_WIDTH-1:0];
                ovf_d[i] = upd[COUNTER_WIDTH] | (overflow_map[i] & ~restart_c);
            end
        end
    end

    // Live counters and sticky flags; overflow_any follows the next-state flags
    always_ff @(posedge clk) begin
        if (rst) begin
            counters     <= '0;
            overflow_map <= '0;
            overflow_any <= 1'b0;
        end else begin
            counters     <= cnt_d;
            overflow_map <= ovf_d;
            overflow_any <= |ovf_d;
        end
    end

    // Snapshot registers take the pre-update live values on capture, then stay frozen
    always_ff @(posedge clk) begin
        if (rst) begin
            snap.snapshot_valid        <= 1'b0;
            snap.snapshot_counters     <= '0;
            snap.snapshot_overflow_map <= '0;
        end else begin
            snap.snapshot_valid <= (state_d == HOLD);
            if (capture_c) begin
                snap.snapshot_counters     <= counters;
                snap.snapshot_overflow_map <= overflow_map;
            end
        end
    end

endmodule
